// File: rtl/stack_seq8.sv
// stack_seq8: byte-wide hardware stack sequencer for an 8-bit core.
// Runs PUSH/POP/CALL/RET as handshaked byte accesses on a fixed stack page.
module stack_seq8 #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] SP_TOP     = 8'hFF,
  parameter int         DEPTH      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  push_data,
  input  logic [15:0] call_pc,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  pop_data,
  output logic [15:0] ret_pc,
  output logic [7:0]  sp
);

  typedef enum logic [2:0] {
    IDLE,
    WR_B,
    WR_L,
    RD_B,
    RD_H
  } state_t;

  localparam logic [8:0] DEPTH_W = DEPTH[8:0];

  state_t      state_q, state_d;
  logic [7:0]  sp_q, sp_d;
  logic        long_q, long_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  pop_q, pop_d;
  logic [15:0] ret_q, ret_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [7:0]  count;
  logic        full_b;
  logic        full_c;
  logic        empty_b;
  logic        empty_r;

  assign count   = SP_TOP - sp_q;
  assign full_b  = {1'b0, count} >= DEPTH_W;
  assign full_c  = ({1'b0, count} + 9'd2) > DEPTH_W;
  assign empty_b = count == 8'd0;
  assign empty_r = count < 8'd2;

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    long_d  = long_q;
    byte_d  = byte_q;
    pc_d    = pc_q;
    lo_d    = lo_q;
    pop_d   = pop_q;
    ret_d   = ret_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            op == 2'd0: begin
              if (full_b) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                state_d = WR_B;
                long_d  = 1'b0;
                byte_d  = push_data;
              end
            end
            op == 2'd1: begin
              if (empty_b) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                state_d = RD_B;
                long_d  = 1'b0;
              end
            end
            op == 2'd2: begin
              if (full_c) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                state_d = WR_B;
                long_d  = 1'b1;
                pc_d    = call_pc;
              end
            end
            op == 2'd3: begin
              if (empty_r) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                state_d = RD_B;
                long_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      WR_B: begin
        if (mem_ready) begin
          sp_d = sp_q - 8'd1;
          if (long_q) begin
            state_d = WR_L;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WR_L: begin
        if (mem_ready) begin
          sp_d    = sp_q - 8'd1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      RD_B: begin
        if (mem_ready) begin
          sp_d = sp_q + 8'd1;
          if (long_q) begin
            // low byte parked until the high byte lands
            lo_d    = mem_rdata;
            state_d = RD_H;
          end else begin
            pop_d   = mem_rdata;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD_H: begin
        if (mem_ready) begin
          sp_d    = sp_q + 8'd1;
          ret_d   = {mem_rdata, lo_q};
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sp_q    <= SP_TOP;
      long_q  <= 1'b0;
      byte_q  <= 8'h00;
      pc_q    <= 16'h0000;
      lo_q    <= 8'h00;
      pop_q   <= 8'h00;
      ret_q   <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      long_q  <= long_d;
      byte_q  <= byte_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      pop_q   <= pop_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // bus outputs decode from registered state only, so they hold through waits
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    unique case (state_q)
      WR_B: begin
        mem_wr    = 1'b1;
        mem_addr  = {STACK_PAGE, sp_q};
        mem_wdata = long_q ? pc_q[15:8] : byte_q;
      end
      WR_L: begin
        mem_wr    = 1'b1;
        mem_addr  = {STACK_PAGE, sp_q};
        mem_wdata = pc_q[7:0];
      end
      RD_B, RD_H: begin
        mem_rd   = 1'b1;
        mem_addr = {STACK_PAGE, sp_q + 8'd1};
      end
      default: ;
    endcase
  end

  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign err      = err_q;
  assign pop_data = pop_q;
  assign ret_pc   = ret_q;
  assign sp       = sp_q;

endmodule

// File: tb/tb_stack_seq8.sv
// tb_stack_seq8: directed and random checks of stack_seq8 against
// a byte-queue stack model with a behavioural memory responder.
module tb_stack_seq8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  push_data;
  logic [15:0] call_pc;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  pop_data;
  logic [15:0] ret_pc;
  logic [7:0]  sp;

  int n_chk;
  int n_err;

  logic [7:0]  mem [256];
  logic [7:0]  stk [$];
  logic [7:0]  pop_exp;
  logic [15:0] ret_exp;

  stack_seq8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .push_data (push_data),
    .call_pc   (call_pc),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pop_data  (pop_data),
    .ret_pc    (ret_pc),
    .sp        (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? mem[mem_addr[7:0]] : 8'h00;

  always @(posedge clk)
    if (mem_wr && mem_ready)
      mem[mem_addr[7:0]] <= mem_wdata;

  function automatic logic [7:0] sp_exp();
    return 8'hFF - 8'(stk.size());
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [7:0] d,
                        input logic [15:0] pc, input int waits);
    logic [7:0] ad [2];
    logic       iw [2];
    logic [7:0] wd [2];
    int         na;
    int         n;
    bit         bad;
    logic [7:0] s;
    logic [7:0] lo;
    logic [7:0] hi;
    n = stk.size();
    s = sp_exp();
    case (o)
      2'd0:    bad = n >= 64;
      2'd1:    bad = n == 0;
      2'd2:    bad = n > 62;
      default: bad = n < 2;
    endcase
    @(negedge clk);
    start = 1'b1;
    op = o;
    push_data = d;
    call_pc = pc;
    mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (bad) begin
      chk("err_done", done, 1);
      chk("err_err", err, 1);
      chk("err_wr", mem_wr, 0);
      chk("err_rd", mem_rd, 0);
      chk("err_busy", busy, 0);
      chk("err_sp", sp, s);
      chk("err_pop", pop_data, pop_exp);
      chk("err_ret", ret_pc, ret_exp);
      return;
    end
    na = 1;
    case (o)
      2'd0: begin
        iw[0] = 1; ad[0] = s; wd[0] = d;
        stk.push_back(d);
      end
      2'd1: begin
        iw[0] = 0; ad[0] = s + 8'd1; wd[0] = 8'h00;
        pop_exp = stk.pop_back();
      end
      2'd2: begin
        na = 2;
        iw[0] = 1; ad[0] = s; wd[0] = pc[15:8];
        iw[1] = 1; ad[1] = s - 8'd1; wd[1] = pc[7:0];
        stk.push_back(pc[15:8]);
        stk.push_back(pc[7:0]);
      end
      default: begin
        na = 2;
        iw[0] = 0; ad[0] = s + 8'd1; wd[0] = 8'h00;
        iw[1] = 0; ad[1] = s + 8'd2; wd[1] = 8'h00;
        lo = stk.pop_back();
        hi = stk.pop_back();
        ret_exp = {hi, lo};
      end
    endcase
    for (int k = 0; k < na; k++) begin
      for (int w = 0; w <= waits; w++) begin
        mem_ready = (w == waits);
        chk("acc_busy", busy, 1);
        chk("acc_done", done, 0);
        chk("acc_wr", mem_wr, iw[k]);
        chk("acc_rd", mem_rd, !iw[k]);
        chk("acc_addr", mem_addr, {8'h01, ad[k]});
        chk("acc_sp", sp, iw[k] ? ad[k] : ad[k] - 8'd1);
        if (iw[k]) chk("acc_wdata", mem_wdata, wd[k]);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    chk("fin_done", done, 1);
    chk("fin_err", err, 0);
    chk("fin_busy", busy, 0);
    chk("fin_sp", sp, sp_exp());
    chk("fin_pop", pop_data, pop_exp);
    chk("fin_ret", ret_pc, ret_exp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    pop_exp = 8'h00;
    ret_exp = 16'h0000;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    push_data = 8'h00;
    call_pc = 16'h0000;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sp", sp, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pop", pop_data, 0);
    chk("rst_ret", ret_pc, 0);

    // first start on the very first edge after reset release
    rst_n = 1'b1;
    start = 1'b1;
    op = 2'd0;
    push_data = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b1;
    chk("p1_wr", mem_wr, 1);
    chk("p1_addr", mem_addr, 16'h01FF);
    chk("p1_wdata", mem_wdata, 8'hA5);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("p1_done", done, 1);
    chk("p1_err", err, 0);
    chk("p1_sp", sp, 8'hFE);
    stk.push_back(8'hA5);

    run_op(2'd1, 8'h00, 16'h0000, 0);
    chk("pop_a5", pop_data, 8'hA5);
    run_op(2'd2, 8'h00, 16'h1234, 0);
    chk("call_sp", sp, 8'hFD);
    run_op(2'd3, 8'h00, 16'h0000, 0);
    chk("ret_1234", ret_pc, 16'h1234);
    run_op(2'd0, 8'h5C, 16'h0000, 3);
    run_op(2'd1, 8'h00, 16'h0000, 1);
    run_op(2'd1, 8'h00, 16'h0000, 0);

    for (int i = 0; i < 64; i++)
      run_op(2'd0, 8'($urandom), 16'h0000, 0);
    run_op(2'd0, 8'h77, 16'h0000, 0);
    chk("ovf_sp", sp, 8'hBF);
    run_op(2'd2, 8'h00, 16'hCAFE, 0);
    for (int i = 0; i < 63; i++)
      run_op(2'd1, 8'h00, 16'h0000, 0);
    run_op(2'd3, 8'h00, 16'h0000, 0);
    run_op(2'd1, 8'h00, 16'h0000, 0);

    // reset dropped while the CALL low byte is on the bus
    @(negedge clk);
    start = 1'b1;
    op = 2'd2;
    call_pc = 16'hBEEF;
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b1;
    chk("rc_wrh", mem_addr, 16'h01FF);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rc_wrl", mem_addr, 16'h01FE);
    chk("rc_wdl", mem_wdata, 8'hEF);
    rst_n = 1'b0;
    #1;
    chk("rc_wr", mem_wr, 0);
    chk("rc_busy", busy, 0);
    chk("rc_sp", sp, 8'hFF);
    chk("rc_addr", mem_addr, 0);
    @(negedge clk);
    chk("rc_done", done, 0);
    rst_n = 1'b1;
    stk.delete();
    pop_exp = 8'h00;
    ret_exp = 16'h0000;
    run_op(2'd1, 8'h00, 16'h0000, 0);

    // start held high: ignored while busy, taken in the done cycle
    @(negedge clk);
    start = 1'b1;
    op = 2'd0;
    push_data = 8'h11;
    @(negedge clk);
    op = 2'd1;
    push_data = 8'h22;
    mem_ready = 1'b1;
    chk("sh_wr", mem_wr, 1);
    chk("sh_wdata", mem_wdata, 8'h11);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("sh_done", done, 1);
    chk("sh_busy", busy, 0);
    chk("sh_sp", sp, 8'hFE);
    @(negedge clk);
    op = 2'd0;
    chk("sh_rd", mem_rd, 1);
    chk("sh_raddr", mem_addr, 16'h01FF);
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b1;
    chk("sh_rd2", mem_rd, 1);
    chk("sh_sp2", sp, 8'hFE);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("sh_pdone", done, 1);
    chk("sh_pop", pop_data, 8'h11);
    chk("sh_sp3", sp, 8'hFF);
    pop_exp = 8'h11;
    @(negedge clk);
    chk("sh_idle", busy, 0);
    chk("sh_nowr", mem_wr, 0);

    for (int i = 0; i < 250; i++)
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
             $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
